// File: rtl/wb_stage_pkg.sv
// Shared pipeline parameters for the writeback stage and its retire counter.
// Other pipeline stages import the same widths so register indices agree.
package wb_stage_pkg;

    localparam int WB_DW    = 16;
    localparam int WB_AW    = 4;
    localparam int RETIRE_W = 16;

endpackage : wb_stage_pkg

// File: rtl/wb_retire_counter.sv
// Saturating up-counter of retired writeback entries; sticks at all-ones.
module wb_retire_counter
    import wb_stage_pkg::*;
#(
    parameter int W = RETIRE_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal written in always_comb gets a value on every path (here the hold value first), otherwise a latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so all flops sample pre-edge values together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule : wb_retire_counter

// File: rtl/wb_stage.sv
// Writeback stage: one registered entry from MEM driving the register-file write
// ports, decode bypass flags, a dual-write collision flag and a retire counter.
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int DW = WB_DW,
    parameter int AW = WB_AW
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                stall,
    input  logic                flush,
    input  logic [AW-1:0]       in_rd1,
    input  logic [AW-1:0]       in_rd2,
    input  logic [DW-1:0]       in_alu_res,
    input  logic [DW-1:0]       in_alu_res2,
    input  logic [DW-1:0]       in_mem_data,
    input  logic                in_mem_to_reg,
    input  logic                in_reg_write,
    input  logic                in_write_op2,
    input  logic [AW-1:0]       id_rs1,
    input  logic [AW-1:0]       id_rs2,
    output logic [AW-1:0]       wb_rd1,
    output logic [AW-1:0]       wb_rd2,
    output logic [DW-1:0]       wb_data1,
    output logic [DW-1:0]       wb_data2,
    output logic                wb_reg_write,
    output logic                wb_write_op2,
    output logic                fwd_a,
    output logic                fwd_b,
    output logic                collision,
    output logic [RETIRE_W-1:0] retire_count
);

    logic          valid_q,      valid_d;
    logic [AW-1:0] rd1_q,        rd1_d;
    logic [AW-1:0] rd2_q,        rd2_d;
    logic [DW-1:0] alu_res_q,    alu_res_d;
    logic [DW-1:0] alu_res2_q,   alu_res2_d;
    logic [DW-1:0] mem_data_q,   mem_data_d;
    logic          mem_to_reg_q, mem_to_reg_d;
    logic          reg_write_q,  reg_write_d;
    logic          write_op2_q,  write_op2_d;

    logic          retire_en;
    logic          port1_wr;

    // Flush only kills the entry; the payload fields keep their last value.
    always_comb begin
        valid_d      = valid_q;
        rd1_d        = rd1_q;
        rd2_d        = rd2_q;
        alu_res_d    = alu_res_q;
        alu_res2_d   = alu_res2_q;
        mem_data_d   = mem_data_q;
        mem_to_reg_d = mem_to_reg_q;
        reg_write_d  = reg_write_q;
        write_op2_d  = write_op2_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d      = in_valid;
            rd1_d        = in_rd1;
            rd2_d        = in_rd2;
            alu_res_d    = in_alu_res;
            alu_res2_d   = in_alu_res2;
            mem_data_d   = in_mem_data;
            mem_to_reg_d = in_mem_to_reg;
            reg_write_d  = in_reg_write;
            write_op2_d  = in_write_op2;
        end
    end

    // NOTE: every entry field is reset, not just valid, so all outputs read 0 while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q      <= 1'b0;
            rd1_q        <= '0;
            rd2_q        <= '0;
            alu_res_q    <= '0;
            alu_res2_q   <= '0;
            mem_data_q   <= '0;
            mem_to_reg_q <= 1'b0;
            reg_write_q  <= 1'b0;
            write_op2_q  <= 1'b0;
        end else begin
            valid_q      <= valid_d;
            rd1_q        <= rd1_d;
            rd2_q        <= rd2_d;
            alu_res_q    <= alu_res_d;
            alu_res2_q   <= alu_res2_d;
            mem_data_q   <= mem_data_d;
            mem_to_reg_q <= mem_to_reg_d;
            reg_write_q  <= reg_write_d;
            write_op2_q  <= write_op2_d;
        end
    end

    // A flush overrides stall, so the held entry leaves the stage and retires.
    assign retire_en = valid_q & (~stall | flush);

    wb_retire_counter #(
        .W (RETIRE_W)
    ) u_retire_counter (
        .clk     (clk),
        .rst     (rst),
        .en_i    (retire_en),
        .count_o (retire_count)
    );

    assign port1_wr     = valid_q & reg_write_q;
    assign collision    = port1_wr & write_op2_q & (rd1_q == rd2_q);
    assign wb_reg_write = port1_wr;
    assign wb_write_op2 = port1_wr & write_op2_q & ~collision;

    assign wb_rd1   = rd1_q;
    assign wb_rd2   = rd2_q;
    assign wb_data1 = mem_to_reg_q ? mem_data_q : alu_res_q;
    assign wb_data2 = alu_res2_q;

    // Only port 1 is bypassed to decode.
    assign fwd_a = port1_wr & (rd1_q == id_rs1);
    assign fwd_b = port1_wr & (rd1_q == id_rs2);

endmodule : wb_stage

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios plus randomized traffic
// compared against a transaction-level model of the held entry.
module tb_wb_stage;

    localparam int DW = 16;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, stall, flush;
    logic [AW-1:0] in_rd1, in_rd2, id_rs1, id_rs2;
    logic [DW-1:0] in_alu_res, in_alu_res2, in_mem_data;
    logic          in_mem_to_reg, in_reg_write, in_write_op2;
    logic [AW-1:0] wb_rd1, wb_rd2;
    logic [DW-1:0] wb_data1, wb_data2;
    logic          wb_reg_write, wb_write_op2, fwd_a, fwd_b, collision;
    logic [15:0]   retire_count;

    int vectors     = 0;
    int miscompares = 0;

    wb_stage #(.DW(DW), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .stall         (stall),
        .flush         (flush),
        .in_rd1        (in_rd1),
        .in_rd2        (in_rd2),
        .in_alu_res    (in_alu_res),
        .in_alu_res2   (in_alu_res2),
        .in_mem_data   (in_mem_data),
        .in_mem_to_reg (in_mem_to_reg),
        .in_reg_write  (in_reg_write),
        .in_write_op2  (in_write_op2),
        .id_rs1        (id_rs1),
        .id_rs2        (id_rs2),
        .wb_rd1        (wb_rd1),
        .wb_rd2        (wb_rd2),
        .wb_data1      (wb_data1),
        .wb_data2      (wb_data2),
        .wb_reg_write  (wb_reg_write),
        .wb_write_op2  (wb_write_op2),
        .fwd_a         (fwd_a),
        .fwd_b         (fwd_b),
        .collision     (collision),
        .retire_count  (retire_count)
    );

    always #5 clk = ~clk;

    // Reference model: the instruction sitting in WB, and how many have left it.
    typedef struct {
        bit            valid;
        logic [AW-1:0] rd1, rd2;
        logic [DW-1:0] alu, alu2, mem;
        bit            m2r, rw, op2;
    } entry_t;

    entry_t m;
    int     m_count;

    task automatic model_reset();
        m       = '{valid: 0, rd1: '0, rd2: '0, alu: '0, alu2: '0, mem: '0, m2r: 0, rw: 0, op2: 0};
        m_count = 0;
    endtask

    task automatic model_edge();
        if (m.valid && (!stall || flush)) m_count = (m_count >= 65535) ? 65535 : m_count + 1;
        if (flush) m.valid = 0;
        else if (!stall)
            m = '{valid: in_valid, rd1: in_rd1, rd2: in_rd2, alu: in_alu_res, alu2: in_alu_res2,
                  mem: in_mem_data, m2r: in_mem_to_reg, rw: in_reg_write, op2: in_write_op2};
    endtask

    task automatic clk_step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic drive_idle();
        in_valid = 0; stall = 0; flush = 0;
        in_rd1 = '0; in_rd2 = '0; id_rs1 = '0; id_rs2 = '0;
        in_alu_res = '0; in_alu_res2 = '0; in_mem_data = '0;
        in_mem_to_reg = 0; in_reg_write = 0; in_write_op2 = 0;
    endtask

    task automatic drive_write(input logic [AW-1:0] rd1, input logic [AW-1:0] rd2,
                               input logic [DW-1:0] alu, input logic [DW-1:0] alu2,
                               input logic [DW-1:0] mem, input bit m2r, input bit rw, input bit op2);
        in_valid = 1; in_rd1 = rd1; in_rd2 = rd2;
        in_alu_res = alu; in_alu_res2 = alu2; in_mem_data = mem;
        in_mem_to_reg = m2r; in_reg_write = rw; in_write_op2 = op2;
    endtask

    task automatic test_reset();
        drive_idle();
        rst = 0;
        model_reset();
        #12;
        vectors++;
        if ({wb_rd1, wb_rd2, wb_data1, wb_data2} !== '0) begin
            miscompares++;
            $display("FAIL reset_ports: got %h, want 0", {wb_rd1, wb_rd2, wb_data1, wb_data2});
        end
        vectors++;
        if ({wb_reg_write, wb_write_op2, fwd_a, fwd_b, collision} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got %b, want 00000", {wb_reg_write, wb_write_op2, fwd_a, fwd_b, collision});
        end
        vectors++;
        if (retire_count !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_count: got %h, want 0000", retire_count);
        end
        @(negedge clk);
        rst = 1;
        @(negedge clk);
    endtask

    task automatic test_alu_writeback();
        drive_write(4'd3, 4'd0, 16'h1234, 16'h0, 16'h0, 0, 1, 0);
        clk_step();
        vectors++;
        if ({wb_rd1, wb_data1, wb_reg_write} !== {4'd3, 16'h1234, 1'b1}) begin
            miscompares++;
            $display("FAIL alu_wb: got rd1=%0d data1=%h we=%b, want rd1=3 data1=1234 we=1", wb_rd1, wb_data1, wb_reg_write);
        end
        drive_idle();
        clk_step();
        vectors++;
        if (retire_count !== 16'd1) begin
            miscompares++;
            $display("FAIL alu_retire: got %0d, want 1", retire_count);
        end
    endtask

    task automatic test_load_dual();
        drive_write(4'd4, 4'd5, 16'hAAAA, 16'h0007, 16'hBEEF, 1, 1, 1);
        clk_step();
        vectors++;
        if ({wb_data1, wb_data2, wb_rd2, wb_write_op2, collision} !== {16'hBEEF, 16'h0007, 4'd5, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL load_dual: got d1=%h d2=%h rd2=%0d we2=%b col=%b, want BEEF 0007 5 1 0",
                     wb_data1, wb_data2, wb_rd2, wb_write_op2, collision);
        end
    endtask

    task automatic test_collision();
        drive_write(4'd6, 4'd6, 16'h1111, 16'h2222, 16'h0, 0, 1, 1);
        clk_step();
        vectors++;
        if ({collision, wb_write_op2, wb_reg_write} !== 3'b101) begin
            miscompares++;
            $display("FAIL collision: got col/we2/we=%b, want 101", {collision, wb_write_op2, wb_reg_write});
        end
    endtask

    task automatic test_stall_flush();
        int held_count;
        drive_write(4'd2, 4'd9, 16'h2222, 16'h0, 16'h0, 0, 1, 0);
        clk_step();
        held_count = m_count;
        stall = 1;
        drive_write(4'd11, 4'd12, 16'hDEAD, 16'hF00D, 16'hCAFE, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            clk_step();
            vectors++;
            if ({wb_rd1, wb_data1, wb_reg_write, wb_write_op2} !== {4'd2, 16'h2222, 1'b1, 1'b0}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got rd1=%0d d1=%h we=%b we2=%b, want 2 2222 1 0",
                         i, wb_rd1, wb_data1, wb_reg_write, wb_write_op2);
            end
            vectors++;
            if (retire_count !== 16'(held_count)) begin
                miscompares++;
                $display("FAIL stall_count[%0d]: got %0d, want %0d", i, retire_count, held_count);
            end
        end
        flush = 1;
        clk_step();
        vectors++;
        if ({retire_count, wb_reg_write} !== {16'(held_count + 1), 1'b0}) begin
            miscompares++;
            $display("FAIL flush: got count=%0d we=%b, want %0d 0", retire_count, wb_reg_write, held_count + 1);
        end
        drive_idle();
        clk_step();
    endtask

    task automatic test_forward();
        drive_write(4'd7, 4'd1, 16'h7777, 16'h0, 16'h0, 0, 1, 0);
        id_rs1 = 4'd7; id_rs2 = 4'd1;
        clk_step();
        vectors++;
        if ({fwd_a, fwd_b} !== 2'b10) begin
            miscompares++;
            $display("FAIL fwd_hit: got %b, want 10", {fwd_a, fwd_b});
        end
        id_rs1 = 4'd1; id_rs2 = 4'd7;
        #1;
        vectors++;
        if ({fwd_a, fwd_b} !== 2'b01) begin
            miscompares++;
            $display("FAIL fwd_b_hit: got %b, want 01", {fwd_a, fwd_b});
        end
        drive_write(4'd7, 4'd7, 16'h7777, 16'h0, 16'h0, 0, 0, 0);
        id_rs1 = 4'd7; id_rs2 = 4'd7;
        clk_step();
        vectors++;
        if ({fwd_a, fwd_b} !== 2'b00) begin
            miscompares++;
            $display("FAIL fwd_no_we: got %b, want 00", {fwd_a, fwd_b});
        end
        drive_idle();
    endtask

    task automatic test_reset_mid_stall();
        drive_write(4'd8, 4'd3, 16'h8888, 16'h3333, 16'h0, 0, 1, 1);
        clk_step();
        stall = 1;
        clk_step();
        #1 rst = 0;
        #1;
        model_reset();
        vectors++;
        if ({wb_rd1, wb_rd2, wb_data1, wb_data2, wb_reg_write, wb_write_op2, collision, retire_count} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got rd1=%0d d1=%h we=%b we2=%b cnt=%0d, want all 0",
                     wb_rd1, wb_data1, wb_reg_write, wb_write_op2, retire_count);
        end
        #1 rst = 1;
        stall = 0;
        drive_write(4'd9, 4'd0, 16'h9999, 16'h0, 16'h0, 0, 1, 0);
        clk_step();
        vectors++;
        if ({wb_rd1, wb_data1, wb_reg_write} !== {4'd9, 16'h9999, 1'b1}) begin
            miscompares++;
            $display("FAIL resume: got rd1=%0d d1=%h we=%b, want 9 9999 1", wb_rd1, wb_data1, wb_reg_write);
        end
        drive_idle();
    endtask

    task automatic test_random();
        logic [DW-1:0] e_d1;
        bit            e_we, e_col, e_we2;
        for (int i = 0; i < 400; i++) begin
            drive_write(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), DW'($urandom()),
                        DW'($urandom()), DW'($urandom()), $urandom_range(0, 1) == 1,
                        $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            in_valid = $urandom_range(0, 4) != 0;
            stall    = $urandom_range(0, 3) == 0;
            flush    = $urandom_range(0, 9) == 0;
            id_rs1   = AW'($urandom_range(0, 3));
            id_rs2   = AW'($urandom_range(0, 3));
            clk_step();
            e_d1  = m.m2r ? m.mem : m.alu;
            e_we  = m.valid && m.rw;
            e_col = e_we && m.op2 && (m.rd1 == m.rd2);
            e_we2 = e_we && m.op2 && !e_col;
            vectors++;
            if ({wb_rd1, wb_rd2, wb_data1, wb_data2} !== {m.rd1, m.rd2, e_d1, m.alu2}) begin
                miscompares++;
                $display("FAIL rnd_ports[%0d]: got %h, want %h", i, {wb_rd1, wb_rd2, wb_data1, wb_data2},
                         {m.rd1, m.rd2, e_d1, m.alu2});
            end
            vectors++;
            if ({wb_reg_write, wb_write_op2, collision} !== {e_we, e_we2, e_col}) begin
                miscompares++;
                $display("FAIL rnd_enables[%0d]: got %b, want %b", i, {wb_reg_write, wb_write_op2, collision},
                         {e_we, e_we2, e_col});
            end
            vectors++;
            if ({fwd_a, fwd_b} !== {e_we && (m.rd1 == id_rs1), e_we && (m.rd1 == id_rs2)}) begin
                miscompares++;
                $display("FAIL rnd_fwd[%0d]: got %b, want %b", i, {fwd_a, fwd_b},
                         {e_we && (m.rd1 == id_rs1), e_we && (m.rd1 == id_rs2)});
            end
            vectors++;
            if (retire_count !== 16'(m_count)) begin
                miscompares++;
                $display("FAIL rnd_count[%0d]: got %0d, want %0d", i, retire_count, m_count);
            end
        end
        drive_idle();
    endtask

    task automatic test_saturation();
        // Count up from a fresh reset: the first step only captures, every later step retires.
        rst = 0;
        model_reset();
        drive_idle();
        #1 rst = 1;
        in_valid = 1; in_reg_write = 1;
        for (int i = 1; i <= 65536; i++) begin
            clk_step();
            if (i == 65535) begin
                vectors++;
                if (retire_count !== 16'hFFFE) begin
                    miscompares++;
                    $display("FAIL sat_near: got %h, want FFFE", retire_count);
                end
            end
        end
        vectors++;
        if (retire_count !== 16'hFFFF) begin
            miscompares++;
            $display("FAIL sat_reach: got %h, want FFFF", retire_count);
        end
        for (int i = 0; i < 4; i++) clk_step();
        vectors++;
        if (retire_count !== 16'hFFFF || m_count != 65535) begin
            miscompares++;
            $display("FAIL sat_hold: got %h, want FFFF", retire_count);
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu_writeback();
        test_load_dual();
        test_collision();
        test_stall_flush();
        test_forward();
        test_reset_mid_stall();
        test_random();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_wb_stage

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DW, default 16, meaning register data width.
REQ-002 SHALL have parameter AW, default 4, meaning register index width (16 registers).
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port in_valid, input, 1, meaning the MEM stage presents an instruction.
REQ-006 SHALL have port stall, input, 1, meaning hold the current WB entry.
REQ-007 SHALL have port flush, input, 1, meaning squash the entry being captured.
REQ-008 SHALL have ports in_rd1 and in_rd2, input, AW each, meaning destination registers for port 1 and port 2.
REQ-009 SHALL have ports in_alu_res, in_alu_res2 and in_mem_data, input, DW each, meaning ALU primary result, ALU secondary result and load data.
REQ-010 SHALL have ports in_mem_to_reg, in_reg_write and in_write_op2, input, 1 each, meaning select load data, write enable and dual-write enable.
REQ-011 SHALL have ports id_rs1 and id_rs2, input, AW each, meaning source registers currently being read in decode.
REQ-012 SHALL have ports wb_rd1 and wb_rd2, output, AW each, and wb_data1 and wb_data2, output, DW each, meaning register-file write ports.
REQ-013 SHALL have ports wb_reg_write and wb_write_op2, output, 1 each, meaning register-file write enables.
REQ-014 SHALL have ports fwd_a and fwd_b, output, 1 each, meaning wb_data1 must bypass the decode read of id_rs1 and id_rs2 respectively.
REQ-015 SHALL have port collision, output, 1, meaning a dual write targets one register.
REQ-016 SHALL have port retire_count, output, 16, meaning the number of retired entries.

Function
REQ-017 SHALL hold one pipeline entry (valid, rd1, rd2, alu_res, alu_res2, mem_data, mem_to_reg, reg_write, write_op2); registers update per rising edge of clk.
REQ-018 SHALL apply the edge update with priority flush > stall > load: flush sets valid=0; stall holds all fields; otherwise loads all fields with valid=in_valid.
REQ-019 SHALL clear valid on flush even when stall=1 at the same edge.
REQ-020 SHALL drive all outputs combinationally from the held entry, giving one cycle latency from MEM inputs to register-file ports.
REQ-021 SHALL drive wb_data1 = in_mem_data when mem_to_reg=1, else in_alu_res (as captured), and wb_data2 = alu_res2.
REQ-022 SHALL drive wb_reg_write = valid & reg_write.
REQ-023 SHALL drive collision = valid & reg_write & write_op2 & (rd1==rd2).
REQ-024 SHALL drive wb_write_op2 = valid & reg_write & write_op2 & !collision, so port 1 wins on a collision.
REQ-025 SHALL drive fwd_a = wb_reg_write & (rd1==id_rs1) and fwd_b = wb_reg_write & (rd1==id_rs2); port 2 is never forwarded.
REQ-026 SHALL, during stall, keep presenting the held write every cycle; the repeated identical write is legal.
REQ-027 SHALL increment retire_count by one at each edge where valid=1 and stall=0, including the flush edge, since the held entry retires before the new entry is squashed.
REQ-028 SHALL saturate retire_count at 16'hFFFF, never wrapping.

Reset
REQ-029 SHALL, when rst=0, asynchronously clear valid, all entry fields and retire_count to 0, so every output reads 0.
REQ-030 SHALL discard a held or stalled entry on reset mid-operation, performing no write.
REQ-031 SHALL resume capture at the first rising edge of clk after rst rises.

Structure
REQ-032 SHALL take DW, AW and the retire_count width from the shared pipeline package.
REQ-033 SHALL contain one natural sub-module, wb_retire_counter, a saturating counter with enable.
REQ-034 SHALL be implemented within the 120-400 line RTL budget, with no memories and a single clock domain.

Verification
REQ-035 SHALL cover ALU writeback: in_valid=1, rd1=3, alu_res=16'h1234, mem_to_reg=0 -> next cycle wb_rd1=3, wb_data1=16'h1234, wb_reg_write=1, retire_count=1.
REQ-036 SHALL cover load and dual write: mem_to_reg=1, mem_data=16'hBEEF, write_op2=1, rd1=4, rd2=5, alu_res2=16'h0007 -> wb_data1=16'hBEEF, wb_data2=16'h0007, wb_write_op2=1.
REQ-037 SHALL cover collision: write_op2=1, rd1=rd2=6 -> collision=1, wb_write_op2=0, wb_reg_write=1.
REQ-038 SHALL cover stall then flush: entry rd1=2 held 3 cycles with stall=1, then flush=1 with stall=1 -> outputs unchanged during the stall, retire_count unchanged during the stall and then incremented once on the flush edge, valid=0 afterwards.
REQ-039 SHALL cover forwarding: held rd1=7 with reg_write=1, id_rs1=7, id_rs2=1 -> fwd_a=1, fwd_b=0; with reg_write=0 -> both 0.
REQ-040 SHALL cover reset mid-stall and saturation: rst=0 asynchronously while stalled -> all outputs 0 without waiting for clk; retire_count preset near 16'hFFFF plus retires -> holds at 16'hFFFF.
